// File: rtl/alu_issue_stage.sv
// Issue stage for the 4-bit aluc ALU: decodes MIPS R/I instructions into ALU controls (stage D)
// and captures the ALU result into an output register (stage R), both under valid/ready flow control.
module alu_issue_stage #(
  parameter logic [5:0] HAMD_FUNCT = 6'b101000,
  parameter int         CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [31:0]      alu_s,
  input  logic             alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic [4:0]       out_dest,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ops_done
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  dest;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  dest;
    logic        illegal;
  } res_t;

  dec_t             dec, d_q, d_d;
  res_t             r_q, r_d;
  logic             d_valid_q, d_valid_d, r_valid_q, r_valid_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             r_adv, d_adv, in_fire, out_fire;

  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign opcode          = inst[31:26];
  assign funct           = inst[5:0];
  assign imm             = inst[15:0];
  assign unused_rs_field = ^inst[25:21];

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b0;
    if (opcode == 6'b000000) begin
      dec.a    = rs_val;
      dec.b    = rt_val;
      dec.dest = inst[15:11];
      if (funct == HAMD_FUNCT) dec.aluc = 4'b1001;
      else begin
        case (funct)
          6'b100000, 6'b100001: dec.aluc = 4'b0000;
          6'b100010, 6'b100011: dec.aluc = 4'b0100;
          6'b100100:            dec.aluc = 4'b0001;
          6'b100101:            dec.aluc = 4'b0101;
          6'b100110:            dec.aluc = 4'b0010;
          // shifts take the amount from the sa field, not rs
          6'b000000: begin dec.aluc = 4'b0011; dec.a = {27'b0, inst[10:6]}; end
          6'b000010: begin dec.aluc = 4'b0111; dec.a = {27'b0, inst[10:6]}; end
          6'b000011: begin dec.aluc = 4'b1111; dec.a = {27'b0, inst[10:6]}; end
          default:              dec.illegal = 1'b1;
        endcase
      end
    end else begin
      dec.a    = rs_val;
      dec.b    = {16'b0, imm};
      dec.dest = inst[20:16];
      case (opcode)
        6'b001000: begin dec.aluc = 4'b0000; dec.b = {{16{imm[15]}}, imm}; end
        6'b001100: dec.aluc = 4'b0001;
        6'b001101: dec.aluc = 4'b0101;
        6'b001110: dec.aluc = 4'b0010;
        6'b001111: begin dec.aluc = 4'b0110; dec.a = '0; end
        default:   dec.illegal = 1'b1;
      endcase
    end
    // illegal ops still flow through the ALU as 0+0 so they retire in order
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign r_adv    = !r_valid_q || out_ready;
  assign d_adv    = d_valid_q && r_adv;
  assign in_ready = !reset && (!d_valid_q || r_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = r_valid_q && out_ready;

  always_comb begin
    d_d       = d_q;
    d_valid_d = d_valid_q;
    r_d       = r_q;
    r_valid_d = r_valid_q;
    ops_d     = ops_q;
    if (in_fire) begin
      d_d       = dec;
      d_valid_d = 1'b1;
    end else if (d_adv) begin
      d_valid_d = 1'b0;
    end
    if (d_adv) begin
      r_d       = '{result: alu_s, zero: alu_z, dest: d_q.dest, illegal: d_q.illegal};
      r_valid_d = 1'b1;
    end else if (out_fire) begin
      r_valid_d = 1'b0;
    end
    if (out_fire) ops_d = ops_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q       <= '0;
      d_valid_q <= 1'b0;
      r_q       <= '0;
      r_valid_q <= 1'b0;
      ops_q     <= '0;
    end else begin
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      r_q       <= r_d;
      r_valid_q <= r_valid_d;
      ops_q     <= ops_d;
    end
  end

  assign alu_a       = d_q.a;
  assign alu_b       = d_q.b;
  assign alu_aluc    = d_q.aluc;
  assign out_valid   = r_valid_q;
  assign out_result  = r_q.result;
  assign out_zero    = r_q.zero;
  assign out_dest    = r_q.dest;
  assign out_illegal = r_q.illegal;
  assign ops_done    = ops_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* loop, instruction-level reference
// model feeding an in-order expectation queue, directed cases plus randomized streams.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] inst, rs_val, rt_val;
  logic [31:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_aluc;
  logic        alu_z;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_dest;
  logic        out_illegal;
  logic [15:0] ops_done;

  always #5 clock = ~clock;

  alu_issue_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs_val(rs_val), .rt_val(rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_dest(out_dest), .out_illegal(out_illegal), .ops_done(ops_done)
  );

  // combinational ALU the stage is meant to drive
  always_comb begin
    alu_s = '0;
    case (alu_aluc)
      4'b0000: alu_s = alu_a + alu_b;
      4'b0100: alu_s = alu_a - alu_b;
      4'b0001: alu_s = alu_a & alu_b;
      4'b0101: alu_s = alu_a | alu_b;
      4'b0010: alu_s = alu_a ^ alu_b;
      4'b0110: alu_s = alu_b << 16;
      4'b0011: alu_s = alu_b << alu_a[4:0];
      4'b0111: alu_s = alu_b >> alu_a[4:0];
      4'b1111: alu_s = $signed(alu_b) >>> alu_a[4:0];
      4'b1001: alu_s = 32'($countones(alu_a ^ alu_b));
      default: alu_s = '0;
    endcase
    alu_z = (alu_s == 32'd0);
  end

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ops_exp;
  logic        held;
  logic [31:0] held_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // instruction semantics straight from the ISA: what the destination register should receive
  function automatic exp_t ref_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [4:0]  sa;
    logic [15:0] im;
    sa    = i[10:6];
    im    = i[15:0];
    e.ill = 1'b0;
    e.res = '0;
    if (i[31:26] == 6'd0) begin
      e.dest = i[15:11];
      case (i[5:0])
        6'd32, 6'd33: e.res = a + b;
        6'd34, 6'd35: e.res = a - b;
        6'd36:        e.res = a & b;
        6'd37:        e.res = a | b;
        6'd38:        e.res = a ^ b;
        6'd40:        e.res = 32'($countones(a ^ b));
        6'd0:         e.res = b << sa;
        6'd2:         e.res = b >> sa;
        6'd3:         e.res = $signed(b) >>> sa;
        default:      e.ill = 1'b1;
      endcase
    end else begin
      e.dest = i[20:16];
      case (i[31:26])
        6'd8:    e.res = a + {{16{im[15]}}, im};
        6'd12:   e.res = a & {16'd0, im};
        6'd13:   e.res = a | {16'd0, im};
        6'd14:   e.res = a ^ {16'd0, im};
        6'd15:   e.res = {im, 16'd0};
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.res  = '0;
      e.dest = '0;
    end
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sa, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sa), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[5:0] = 6'd32;  1: r[5:0] = 6'd34;  2: r[5:0] = 6'd36;  3: r[5:0] = 6'd37;
      4: r[5:0] = 6'd38;  5: r[5:0] = 6'd40;  6: r[5:0] = 6'd0;   7: r[5:0] = 6'd2;
      8: r[5:0] = 6'd3;   9: r[5:0] = 6'd35;
      default: ;
    endcase
    if (k <= 9) r[31:26] = 6'd0;
    else if (k == 10) r[31:26] = 6'd8;
    else if (k == 11) r[31:26] = 6'd12;
    else if (k == 12) r[31:26] = 6'd13;
    else if (k == 13) r[31:26] = 6'd14;
    else if (k == 14) r[31:26] = 6'd15;
    return r;
  endfunction

  // one cycle, entered and left at a falling edge: drive, observe handshakes, then clock
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic ordy, output logic acc);
    exp_t e;
    in_valid = iv; inst = ins; rs_val = a; rt_val = b; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (held && out_valid) chk("stall_hold", out_result, held_res);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("zero", 32'(out_zero), 32'(e.z));
        chk("dest", 32'(out_dest), 32'(e.dest));
        chk("illegal", 32'(out_illegal), 32'(e.ill));
      end
      ops_exp++;
    end
    held     = out_valid && !out_ready;
    held_res = out_result;
    if (acc) q.push_back(ref_op(ins, a, b));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send1(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(1'b1, ins, a, b, 1'b1, acc);
      n++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      step(1'b0, '0, '0, '0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    ops_exp = '0;
    held    = 1'b0;
  endtask

  initial begin
    logic        acc;
    logic [31:0] nxt_i, nxt_a, nxt_b;
    int          n_acc, c;
    logic [3:0]  pat;

    reset = 1'b1; in_valid = 1'b0; inst = '0; rs_val = '0; rt_val = '0; out_ready = 1'b0;
    ops_exp = '0; held = 1'b0; held_res = '0;
    @(negedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_aluc", 32'(alu_aluc), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // add with latency checks
    step(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, acc);
    chk("add_accepted", 32'(acc), 32'd1);
    chk("add_lat_not_yet", 32'(out_valid), 32'd0);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_aluc", 32'(alu_aluc), 32'd0);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    chk("add_lat_valid", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'd12);
    chk("add_dest", 32'(out_dest), 32'd3);
    drain();

    // directed corner cases, back-to-back
    send1(rtype(1, 2, 4, 0, 6'd34), 32'h1234, 32'h1234);
    send1(rtype(0, 2, 5, 4, 6'd3), 32'd0, 32'hF000_0000);
    chk("sra_aluc", 32'(alu_aluc), 32'hF);
    send1(itype(6'd15, 0, 6, 16'hABCD), 32'hDEAD_BEEF, 32'd0);
    chk("lui_alu_a", alu_a, 32'd0);
    send1(rtype(1, 2, 7, 0, 6'b101000), 32'hFFFF_0000, 32'd0);
    chk("hamd_aluc", 32'(alu_aluc), 32'd9);
    send1(itype(6'b111111, 3, 8, 16'h1111), 32'd99, 32'd42);
    send1(itype(6'd8, 1, 9, 16'hFFFE), 32'd1, 32'd0);
    drain();
    chk("directed_ops_done", 32'(ops_done), 32'(ops_exp));

    // backpressure: 8 ops, out_ready pattern 1-0-0-1
    do_reset();
    pat   = 4'b1001;
    n_acc = 0;
    c     = 0;
    nxt_i = rand_inst(); nxt_a = $urandom; nxt_b = $urandom;
    while ((n_acc < 8 || q.size() != 0) && c < 200) begin
      step(n_acc < 8, nxt_i, nxt_a, nxt_b, pat[c % 4], acc);
      if (acc) begin
        n_acc++;
        nxt_i = rand_inst(); nxt_a = $urandom; nxt_b = $urandom;
      end
      c++;
    end
    chk("bp_accepted", 32'(n_acc), 32'd8);
    chk("bp_ops_done", 32'(ops_done), 32'd8);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom_range(0, 2) != 0, acc);
    end
    drain();
    chk("rand_ops_done", 32'(ops_done), 32'(ops_exp));

    // asynchronous reset with D and R both occupied
    step(1'b1, rtype(1, 2, 3, 0, 6'd32), 32'd1, 32'd2, 1'b0, acc);
    step(1'b1, rtype(1, 2, 4, 0, 6'd37), 32'd8, 32'd3, 1'b0, acc);
    chk("mid_r_full", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_ops_done", 32'(ops_done), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    ops_exp = '0;
    held    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    send1(32'h0022_1820, 32'd20, 32'd22);
    drain();
    chk("post_rst_ops_done", 32'(ops_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
